// File: rtl/rob_issue_sched.sv
// Oldest-ready issue scheduler for the shared execute unit: picks the ready ROB entry
// nearest rob_head (with wrap), issues ALU ops in one cycle and holds the unit for loads.
module rob_issue_sched #(
    parameter int ROB_SIZE     = 8,
    parameter int ROB_SIZE_LOG = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [ROB_SIZE_LOG-1:0] rob_head,
    input  logic [ROB_SIZE-1:0]     ready_vec,
    input  logic [ROB_SIZE-1:0]     mem_vec,
    output logic                    issue_valid,
    output logic [ROB_SIZE_LOG-1:0] issue_idx,
    output logic [ROB_SIZE-1:0]     issue_onehot,
    output logic                    mem_req_valid,
    input  logic                    mem_resp_valid,
    output logic                    finish_valid,
    output logic [ROB_SIZE_LOG-1:0] finish_idx,
    output logic                    busy
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MEM_WAIT  = 2'd1,
        ST_MEM_DRAIN = 2'd2
    } state_t;

    state_t                  r_state;
    logic [ROB_SIZE_LOG-1:0] r_mem_idx;

    logic                    w_found;
    logic [ROB_SIZE_LOG-1:0] w_sel;
    logic [ROB_SIZE_LOG-1:0] w_cand;
    logic                    w_can_issue;
    logic                    w_sel_is_load;
    logic                    w_load_done;

    // Walk entries in age order starting at the head; the first ready one is the oldest.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_cand  = '0;
        for (int unsigned k = 0; k < ROB_SIZE; k++) begin
            w_cand = rob_head + ROB_SIZE_LOG'(k);
            if (!w_found && ready_vec[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end

    always_comb begin
        w_can_issue   = !rst && !flush && (r_state == ST_IDLE) && w_found;
        w_sel_is_load = mem_vec[w_sel];
        w_load_done   = !rst && !flush && (r_state == ST_MEM_WAIT) && mem_resp_valid;

        issue_valid   = w_can_issue;
        issue_idx     = w_can_issue ? w_sel : '0;
        issue_onehot  = w_can_issue ? (ROB_SIZE'(1) << w_sel) : '0;
        mem_req_valid = w_can_issue && w_sel_is_load;

        finish_valid  = 1'b0;
        finish_idx    = '0;
        if (w_can_issue && !w_sel_is_load) begin
            finish_valid = 1'b1;
            finish_idx   = w_sel;
        end else if (w_load_done) begin
            finish_valid = 1'b1;
            finish_idx   = r_mem_idx;
        end

        busy = !rst && (r_state != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_mem_idx <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_can_issue && w_sel_is_load) begin
                        r_state   <= ST_MEM_WAIT;
                        r_mem_idx <= w_sel;
                    end
                end
                ST_MEM_WAIT: begin
                    // A response coinciding with flush is simply dropped.
                    if (mem_resp_valid)
                        r_state <= ST_IDLE;
                    else if (flush)
                        r_state <= ST_MEM_DRAIN;
                end
                ST_MEM_DRAIN: begin
                    if (mem_resp_valid)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rob_issue_sched.sv
// Directed bench for rob_issue_sched: age wrap, load wait, flush/drain and reset cases.
module tb_rob_issue_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [2:0] rob_head;
    logic [7:0] ready_vec;
    logic [7:0] mem_vec;
    logic       mem_resp_valid;
    logic       issue_valid;
    logic [2:0] issue_idx;
    logic [7:0] issue_onehot;
    logic       mem_req_valid;
    logic       finish_valid;
    logic [2:0] finish_idx;
    logic       busy;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    rob_issue_sched #(.ROB_SIZE(8), .ROB_SIZE_LOG(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .rob_head       (rob_head),
        .ready_vec      (ready_vec),
        .mem_vec        (mem_vec),
        .issue_valid    (issue_valid),
        .issue_idx      (issue_idx),
        .issue_onehot   (issue_onehot),
        .mem_req_valid  (mem_req_valid),
        .mem_resp_valid (mem_resp_valid),
        .finish_valid   (finish_valid),
        .finish_idx     (finish_idx),
        .busy           (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge, then apply inputs for that cycle.
    task automatic cycle_in(input logic r, input logic f, input logic [2:0] h,
                            input logic [7:0] rdy, input logic [7:0] mv, input logic resp);
        @(posedge clk);
        #1;
        rst = r; flush = f; rob_head = h; ready_vec = rdy; mem_vec = mv; mem_resp_valid = resp;
        #2;
    endtask

    task automatic check_all(input string tag, input logic iv, input logic [2:0] ii,
                             input logic [7:0] oh, input logic mr, input logic fv,
                             input logic [2:0] fi, input logic b);
        check({tag, ".issue_valid"},   32'(issue_valid),   32'(iv));
        check({tag, ".issue_idx"},     32'(issue_idx),     32'(ii));
        check({tag, ".issue_onehot"},  32'(issue_onehot),  32'(oh));
        check({tag, ".mem_req_valid"}, 32'(mem_req_valid), 32'(mr));
        check({tag, ".finish_valid"},  32'(finish_valid),  32'(fv));
        check({tag, ".finish_idx"},    32'(finish_idx),    32'(fi));
        check({tag, ".busy"},          32'(busy),          32'(b));
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; rob_head = '0; ready_vec = 8'hFF; mem_vec = '0; mem_resp_valid = 1'b0;

        // Reset holds every output low.
        cycle_in(1, 0, 3'd0, 8'hFF, 8'h00, 0);
        check_all("rst", 0, 0, 8'h00, 0, 0, 0, 0);

        // First cycle after reset: ALU op at entry 0 issues and finishes.
        cycle_in(0, 0, 3'd0, 8'hFF, 8'h00, 0);
        check_all("post_rst", 1, 0, 8'h01, 0, 1, 0, 0);

        // Age wrap-around.
        cycle_in(0, 0, 3'd6, 8'b0100_0001, 8'h00, 0);
        check_all("wrap_h6", 1, 6, 8'h40, 0, 1, 6, 0);
        cycle_in(0, 0, 3'd7, 8'b0100_0001, 8'h00, 0);
        check_all("wrap_h7", 1, 0, 8'h01, 0, 1, 0, 0);
        cycle_in(0, 0, 3'd5, 8'h18, 8'h00, 0);
        check_all("wrap_h5", 1, 3, 8'h08, 0, 1, 3, 0);
        cycle_in(0, 0, 3'd7, 8'h80, 8'h00, 0);
        check_all("head_only", 1, 7, 8'h80, 0, 1, 7, 0);

        // Nothing ready; a stray response in IDLE is ignored.
        cycle_in(0, 0, 3'd0, 8'h00, 8'h00, 1);
        check_all("idle_resp", 0, 0, 8'h00, 0, 0, 0, 0);

        // Load with response three cycles later.
        cycle_in(0, 0, 3'd0, 8'h03, 8'h01, 0);
        check_all("ld_c0", 1, 0, 8'h01, 1, 0, 0, 0);
        cycle_in(0, 0, 3'd0, 8'h03, 8'h01, 0);
        check_all("ld_c1", 0, 0, 8'h00, 0, 0, 0, 1);
        cycle_in(0, 0, 3'd0, 8'h03, 8'h01, 0);
        check_all("ld_c2", 0, 0, 8'h00, 0, 0, 0, 1);
        cycle_in(0, 0, 3'd0, 8'h03, 8'h01, 1);
        check_all("ld_c3", 0, 0, 8'h00, 0, 1, 0, 1);
        cycle_in(0, 0, 3'd0, 8'h02, 8'h00, 0);
        check_all("ld_c4", 1, 1, 8'h02, 0, 1, 1, 0);

        // Flush while waiting on a load: drain, then resume.
        cycle_in(0, 0, 3'd0, 8'h04, 8'h04, 0);
        check_all("fl_issue", 1, 2, 8'h04, 1, 0, 0, 0);
        cycle_in(0, 1, 3'd0, 8'hFF, 8'h00, 0);
        check_all("fl_wait", 0, 0, 8'h00, 0, 0, 0, 1);
        cycle_in(0, 0, 3'd0, 8'hFF, 8'h00, 0);
        check_all("drain1", 0, 0, 8'h00, 0, 0, 0, 1);
        cycle_in(0, 0, 3'd0, 8'hFF, 8'h00, 1);
        check_all("drain_resp", 0, 0, 8'h00, 0, 0, 0, 1);
        cycle_in(0, 0, 3'd0, 8'hFF, 8'h00, 0);
        check_all("after_drain", 1, 0, 8'h01, 0, 1, 0, 0);

        // Flush and response together in MEM_WAIT: response dropped, back to IDLE.
        cycle_in(0, 0, 3'd2, 8'h08, 8'h08, 0);
        check_all("fr_issue", 1, 3, 8'h08, 1, 0, 0, 0);
        cycle_in(0, 1, 3'd2, 8'h08, 8'h08, 1);
        check_all("fr_same", 0, 0, 8'h00, 0, 0, 0, 1);
        cycle_in(0, 0, 3'd2, 8'h10, 8'h00, 0);
        check_all("fr_next", 1, 4, 8'h10, 0, 1, 4, 0);

        // Flush in IDLE suppresses issue.
        cycle_in(0, 1, 3'd0, 8'h04, 8'h00, 0);
        check_all("fl_idle", 0, 0, 8'h00, 0, 0, 0, 0);
        cycle_in(0, 0, 3'd0, 8'h04, 8'h00, 0);
        check_all("fl_idle_next", 1, 2, 8'h04, 0, 1, 2, 0);

        // Reset in the middle of a load returns straight to IDLE.
        cycle_in(0, 0, 3'd0, 8'h20, 8'h20, 0);
        check_all("rl_issue", 1, 5, 8'h20, 1, 0, 0, 0);
        cycle_in(1, 0, 3'd0, 8'hFF, 8'hFF, 1);
        check_all("rl_rst", 0, 0, 8'h00, 0, 0, 0, 0);
        cycle_in(0, 0, 3'd1, 8'h01, 8'h00, 0);
        check_all("rl_after", 1, 0, 8'h01, 0, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
